// File: rtl/trace_capture_if.sv
// Trace capture port bundle: processor sample inputs and the trace FIFO output handshake.
// master = stimulus/consumer side, slave = trace_capture.
interface trace_capture_if;
    logic [15:0] curr_pc;
    logic [15:0] curr_instr;
    logic        trace_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_instr;
    logic [7:0]  out_seq;
    logic [7:0]  overflow_cnt;
    logic        halted;

    modport master (
        output curr_pc, curr_instr, trace_en, out_ready,
        input  out_valid, out_pc, out_instr, out_seq, overflow_cnt, halted
    );

    modport slave (
        input  curr_pc, curr_instr, trace_en, out_ready,
        output out_valid, out_pc, out_instr, out_seq, overflow_cnt, halted
    );
endinterface

// File: rtl/trace_capture.sv
// Processor PC/instruction trace capture into a DEPTH-entry FIFO with halt detection and drop counting.
// Optional TRACE_FILTER_EN: skip samples whose PC repeats the previously sampled PC.
module trace_capture #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [15:0] HALT_INSTR = 16'hE071
) (
    input  logic            clk,
    input  logic            reset,
    trace_capture_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HALTED  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [7:0]  seq;
    } entry_t;

    state_t        state;
    state_t        state_n;
    entry_t        mem [DEPTH];
    entry_t        sample;
    entry_t        head;
    entry_t        head_n;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_n;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_n;
    logic [7:0]    seq_cnt;
    logic [7:0]    seq_cnt_n;
    logic [7:0]    ovf_cnt;
    logic [7:0]    ovf_cnt_n;
    logic          valid_q;
    logic          valid_n;
    logic          halted_q;
    logic          sample_take;
    logic          dup_pc;
    logic          full;
    logic          push;
    logic          pop;

`ifdef TRACE_FILTER_EN
    logic [15:0] prev_pc;
    logic        prev_pc_vld;

    assign dup_pc = prev_pc_vld && (bus.curr_pc == prev_pc);

    // Previous-PC tracker, forgotten whenever capture is left
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_pc     <= '0;
            prev_pc_vld <= 1'b0;
        end else if (state_n != CAPTURE) begin
            prev_pc_vld <= 1'b0;
        end else if (sample_take) begin
            prev_pc     <= bus.curr_pc;
            prev_pc_vld <= 1'b1;
        end
    end
`else
    assign dup_pc = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and sample decision
    always_comb begin
        state_n     = state;
        sample_take = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.trace_en) begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!bus.trace_en) begin
                    state_n = IDLE;
                end else if (!dup_pc) begin
                    sample_take = 1'b1;
                    if (bus.curr_instr == HALT_INSTR) begin
                        state_n = HALTED;
                    end
                end
            end
            HALTED: begin
                if (!bus.trace_en) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sample = '{pc: bus.curr_pc, instr: bus.curr_instr, seq: seq_cnt};
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop    = valid_q && bus.out_ready;
    assign push   = sample_take && (!full || pop);

    // Next pointers, counters and head entry; head is preloaded so outputs come straight from flops
    always_comb begin
        wr_ptr_n  = wr_ptr + PW'(push);
        rd_ptr_n  = rd_ptr + PW'(pop);
        valid_n   = (wr_ptr_n != rd_ptr_n);
        seq_cnt_n = seq_cnt + 8'(sample_take);
        ovf_cnt_n = ovf_cnt;
        head_n    = head;
        if (sample_take && !push && (ovf_cnt != 8'hFF)) begin
            ovf_cnt_n = ovf_cnt + 8'd1;
        end
        if (push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
            head_n = sample;
        end else if (valid_n) begin
            head_n = mem[rd_ptr_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq_cnt  <= '0;
            ovf_cnt  <= '0;
            head     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            seq_cnt  <= seq_cnt_n;
            ovf_cnt  <= ovf_cnt_n;
            head     <= head_n;
            valid_q  <= valid_n;
            halted_q <= (state_n == HALTED);
        end
    end

    // Storage needs no reset: validity is carried by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= sample;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_pc       = head.pc;
    assign bus.out_instr    = head.instr;
    assign bus.out_seq      = head.seq;
    assign bus.overflow_cnt = ovf_cnt;
    assign bus.halted       = halted_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: directed capture sequences, monitor checks every popped entry.
// Honors TRACE_FILTER_EN for the duplicate-PC scenario.
module tb_trace_capture;
    logic clk;
    logic reset;

    trace_capture_if tb_if ();

    trace_capture #(.DEPTH(16), .HALT_INSTR(16'hE071)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tb_if)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [7:0]  seq;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_entry(input logic [15:0] pc, input logic [15:0] instr, input logic [7:0] seq);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.seq   = seq;
        sb.push_back(e);
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the rising edge
    task automatic step(input logic en, input logic [15:0] pc, input logic [15:0] instr, input logic rdy);
        tb_if.trace_en   = en;
        tb_if.curr_pc    = pc;
        tb_if.curr_instr = instr;
        tb_if.out_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        tb_if.trace_en   = 1'b0;
        tb_if.curr_pc    = '0;
        tb_if.curr_instr = '0;
        tb_if.out_ready  = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 24; i++) step(1'b0, 16'h0, 16'h0, 1'b1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({name, "_valid_low"}, 32'(tb_if.out_valid), 32'd0);
    endtask

    // Monitor: every accepted handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!reset && tb_if.out_valid && tb_if.out_ready) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_entry actual pc=%0h instr=%0h seq=%0d required=none",
                         tb_if.out_pc, tb_if.out_instr, tb_if.out_seq);
            end else begin
                e = sb.pop_front();
                if ({tb_if.out_pc, tb_if.out_instr, tb_if.out_seq} !== e) begin
                    failures++;
                    $display("FAIL entry actual pc=%0h instr=%0h seq=%0d required pc=%0h instr=%0h seq=%0d",
                             tb_if.out_pc, tb_if.out_instr, tb_if.out_seq, e.pc, e.instr, e.seq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        tb_if.trace_en   = 1'b0;
        tb_if.curr_pc    = '0;
        tb_if.curr_instr = '0;
        tb_if.out_ready  = 1'b0;
        #3;
        check("rst_valid",    32'(tb_if.out_valid),    32'd0);
        check("rst_pc",       32'(tb_if.out_pc),       32'd0);
        check("rst_instr",    32'(tb_if.out_instr),    32'd0);
        check("rst_seq",      32'(tb_if.out_seq),      32'd0);
        check("rst_overflow", 32'(tb_if.overflow_cnt), 32'd0);
        check("rst_halted",   32'(tb_if.halted),       32'd0);

        // Basic capture with one-cycle latency
        do_reset();
        step(1'b1, 16'h00AA, 16'h1111, 1'b1);
        check("basic_no_entry_sample", 32'(tb_if.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_entry(16'(i), 16'(16'h1000 + i), 8'(i));
            step(1'b1, 16'(i), 16'(16'h1000 + i), 1'b1);
            check("basic_latency_valid", 32'(tb_if.out_valid), 32'd1);
            check("basic_latency_pc",    32'(tb_if.out_pc),    32'(i));
        end
        drain("basic");
        check("basic_overflow", 32'(tb_if.overflow_cnt), 32'd0);

        // Overflow, full-with-pop, saturation, drain in order
        do_reset();
        step(1'b1, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) expect_entry(16'(16'h0100 + i), 16'(16'h2000 + i), 8'(i));
            step(1'b1, 16'(16'h0100 + i), 16'(16'h2000 + i), 1'b0);
        end
        check("ovf_count4",   32'(tb_if.overflow_cnt), 32'd4);
        check("ovf_head_seq", 32'(tb_if.out_seq),      32'd0);
        check("ovf_head_pc",  32'(tb_if.out_pc),       32'h0100);
        expect_entry(16'h0114, 16'h2014, 8'd20);
        step(1'b1, 16'h0114, 16'h2014, 1'b1);
        check("fullpop_overflow", 32'(tb_if.overflow_cnt), 32'd4);
        check("fullpop_head_seq", 32'(tb_if.out_seq),      32'd1);
        for (int i = 21; i < 281; i++) step(1'b1, 16'(16'h0100 + i), 16'(16'h2000 + i), 1'b0);
        check("ovf_saturate", 32'(tb_if.overflow_cnt), 32'd255);
        step(1'b0, 16'h0, 16'h0, 1'b0);
        check("ovf_stable_seq", 32'(tb_if.out_seq), 32'd1);
        drain("ovf");
        check("ovf_hold_after_drain", 32'(tb_if.overflow_cnt), 32'd255);

        // Halt detection
        do_reset();
        step(1'b1, 16'h0, 16'h0, 1'b1);
        expect_entry(16'h0003, 16'h3003, 8'd0);
        step(1'b1, 16'h0003, 16'h3003, 1'b1);
        expect_entry(16'h0004, 16'h3004, 8'd1);
        step(1'b1, 16'h0004, 16'h3004, 1'b1);
        check("halt_low_before", 32'(tb_if.halted), 32'd0);
        expect_entry(16'h0005, 16'hE071, 8'd2);
        step(1'b1, 16'h0005, 16'hE071, 1'b1);
        check("halt_high", 32'(tb_if.halted), 32'd1);
        step(1'b1, 16'h0006, 16'h3006, 1'b1);
        step(1'b1, 16'h0007, 16'h3007, 1'b1);
        check("halt_held", 32'(tb_if.halted), 32'd1);
        step(1'b0, 16'h0008, 16'h3008, 1'b1);
        check("halt_release", 32'(tb_if.halted), 32'd0);
        drain("halt");

        // Asynchronous reset mid-capture
        do_reset();
        step(1'b1, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0020 + i), 16'(16'h4000 + i), 1'b0);
        check("arst_prefill_valid", 32'(tb_if.out_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid_now", 32'(tb_if.out_valid), 32'd0);
        check("arst_seq_now",   32'(tb_if.out_seq),    32'd0);
        #1;
        reset = 1'b0;
        step(1'b1, 16'h0, 16'h0, 1'b1);
        check("arst_no_entry_sample", 32'(tb_if.out_valid), 32'd0);
        expect_entry(16'h0040, 16'h4040, 8'd0);
        step(1'b1, 16'h0040, 16'h4040, 1'b1);
        expect_entry(16'h0041, 16'h4041, 8'd1);
        step(1'b1, 16'h0041, 16'h4041, 1'b1);
        drain("arst");

        // Duplicate-PC sequence
        do_reset();
        step(1'b1, 16'h0, 16'h0, 1'b1);
`ifdef TRACE_FILTER_EN
        expect_entry(16'h0004, 16'h5004, 8'd0);
        expect_entry(16'h0005, 16'h5005, 8'd1);
`else
        expect_entry(16'h0004, 16'h5004, 8'd0);
        expect_entry(16'h0004, 16'h5004, 8'd1);
        expect_entry(16'h0004, 16'h5004, 8'd2);
        expect_entry(16'h0005, 16'h5005, 8'd3);
`endif
        step(1'b1, 16'h0004, 16'h5004, 1'b1);
        step(1'b1, 16'h0004, 16'h5004, 1'b1);
        step(1'b1, 16'h0004, 16'h5004, 1'b1);
        step(1'b1, 16'h0005, 16'h5005, 1'b1);
        drain("filter");
        check("filter_overflow", 32'(tb_if.overflow_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entry count; power of two, 4..64.
REQ-002 Parameter HALT_INSTR, default 16'hE071, instruction word that marks processor halt.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 curr_pc  input  16  processor PC for the current cycle.
REQ-006 curr_instr  input  16  instruction at curr_pc for the current cycle.
REQ-007 trace_en  input  1  capture enable, level-sensitive.
REQ-008 out_valid  output  1  trace entry available at the output.
REQ-009 out_ready  input  1  consumer accepts the entry.
REQ-010 out_pc / out_instr  output  16 / 16  head entry PC and instruction.
REQ-011 out_seq  output  8  head entry sequence number.
REQ-012 overflow_cnt  output  8  dropped-sample count, saturating.
REQ-013 halted  output  1  high while in HALTED state.

Function
REQ-014 The FSM SHALL have states IDLE, CAPTURE and HALTED.
REQ-015 IDLE SHALL go to CAPTURE on trace_en=1; no sample is taken in the transition cycle.
REQ-016 CAPTURE SHALL form one sample per cycle from {curr_pc, curr_instr, seq_cnt}.
REQ-017 CAPTURE SHALL go to IDLE when trace_en=0; the sample in that cycle is not taken.
REQ-018 CAPTURE SHALL go to HALTED when the sampled curr_instr equals HALT_INSTR; the halt sample is pushed like any other sample.
REQ-019 HALTED SHALL take no samples and SHALL go to IDLE only when trace_en=0.
REQ-020 seq_cnt SHALL increment by 1 for every sample formed, accepted or dropped, and SHALL wrap from 255 to 0.
REQ-021 A sample SHALL be pushed if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-022 Otherwise the sample SHALL be dropped and overflow_cnt SHALL increment, holding at 255.
REQ-023 A pop SHALL occur when out_valid=1 and out_ready=1 in the same cycle.
REQ-024 out_valid SHALL equal FIFO not-empty.
REQ-025 out_pc, out_instr and out_seq SHALL show the head entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 Latency SHALL be one cycle: a sample pushed at edge N into an empty FIFO shows out_valid=1 after edge N.
REQ-027 When the FIFO is empty, a simultaneous push and pop SHALL NOT bypass; the pop is ignored because out_valid=0.
REQ-028 Draining SHALL continue in all states, including IDLE and HALTED.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be told apart by an extra pointer bit.

Reset
REQ-030 On reset the state SHALL be IDLE, the FIFO empty, and seq_cnt=0.
REQ-031 On reset, out_valid=0, out_pc=0, out_instr=0, out_seq=0, overflow_cnt=0 and halted=0.
REQ-032 Reset asserted mid-capture SHALL discard all FIFO contents immediately, without waiting for a clock edge.
REQ-033 The first sample after reset deassertion SHALL carry out_seq=0.

Configuration
REQ-034 With TRACE_FILTER_EN defined, a CAPTURE sample whose curr_pc equals the previous sampled PC SHALL be skipped: no push, no seq_cnt increment, no overflow increment.
REQ-035 The previous sampled PC SHALL be invalid after reset and after leaving CAPTURE.
REQ-036 With TRACE_FILTER_EN undefined, every CAPTURE cycle SHALL form a sample.

Verification
REQ-037 Basic capture: reset, trace_en=1, PC 0,1,2,3 with out_ready=1 -> outputs (pc 0..3, seq 0..3), each one cycle after its sample; overflow_cnt=0.
REQ-038 Overflow: DEPTH=16, out_ready=0, 20 capture cycles -> 16 entries held, overflow_cnt=4; then drain -> seq 0..15 in order.
REQ-039 Full with pop: FIFO full, out_ready=1 in one capture cycle -> push accepted, count stays 16, overflow_cnt unchanged.
REQ-040 Halt: instruction 16'hE071 at PC 0x0005 -> that entry is captured, halted=1 next cycle, later samples ignored; trace_en=0 -> IDLE, halted=0.
REQ-041 Reset during capture: 5 entries queued, reset pulsed between clock edges -> out_valid=0 immediately; recapture after release starts at seq 0.
REQ-042 Filter: with TRACE_FILTER_EN, PC sequence 4,4,4,5 -> two entries (pc 4 seq 0, pc 5 seq 1); without the macro -> four entries, seq 0..3.
